serial_bit_source: RTL and testbench

//   Parallel-to-serial stage directly upstream of moore_seq.

---
 rtl/serial_bit_source.sv | 117 +++++++++++
 tb/tb_serial_bit_source.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_source.sv
// Parallel-to-serial source feeding moore_seq: one word in over load/ready, one bit per clock out on x.
// Define SER_PARITY_EN to append an even-parity bit after the data bits of every word.
`timescale 1ns/1ps

module serial_bit_source #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

`ifdef SER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam logic [3:0] LAST_CNT = 4'(NBITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             done_q, done_d;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    // cnt is the index of the bit currently on x, so the last-bit cycle can take a new word.
    assign ready   = (state_q == IDLE) || (cnt_q == LAST_CNT);
    assign accept  = load && ready;
    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
        done_d    = 1'b0;
`ifdef SER_PARITY_EN
        parity_d  = parity_q;
`endif
        if (accept) begin
            state_d   = SHIFT;
            cnt_d     = 4'd0;
            shreg_d   = advance(din);
            x_d       = head_bit(din);
            x_valid_d = 1'b1;
`ifdef SER_PARITY_EN
            parity_d  = ^din;
`endif
        end else if (state_q == SHIFT) begin
            if (cnt_q == LAST_CNT) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d     = cnt_q + 4'd1;
                shreg_d   = advance(shreg_q);
                x_d       = head_bit(shreg_q);
                x_valid_d = 1'b1;
                done_d    = (cnt_q + 4'd1 == LAST_CNT);
`ifdef SER_PARITY_EN
                if (cnt_q + 4'd1 == 4'(WIDTH)) begin
                    x_d = parity_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
        end
    end

    // NOTE: the word store is not reset; it is always rewritten on the accepting edge before use.
    always_ff @(posedge clock) begin
        shreg_q  <= shreg_d;
`ifdef SER_PARITY_EN
        parity_q <= parity_d;
`endif
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: queue-based bit-stream model compared every cycle, plus directed
// word streams with literal expectations; random load/reset traffic at the end.
`timescale 1ns/1ps

module tb_serial_bit_source;

    localparam int   WIDTH     = 8;
    localparam int   MSB_FIRST = 1;
    localparam logic IDLE_BIT  = 1'b0;
`ifdef SER_PARITY_EN
    localparam int   NB        = WIDTH + 1;
`else
    localparam int   NB        = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             load  = 1'b0;
    logic [WIDTH-1:0] din   = '0;
    logic             ready, x, x_valid, done;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    serial_bit_source #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST),
        .IDLE_BIT (IDLE_BIT)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .din    (din),
        .load   (load),
        .ready  (ready),
        .x      (x),
        .x_valid(x_valid),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the bits still to appear on x, front element being on x now.
    bit model_q[$];

    function automatic void load_word(input logic [WIDTH-1:0] w);
        model_q.delete();
        for (int i = 0; i < WIDTH; i++)
            model_q.push_back((MSB_FIRST != 0) ? w[WIDTH-1-i] : w[i]);
`ifdef SER_PARITY_EN
        model_q.push_back(^w);
`endif
    endfunction

    always @(posedge clock) begin
        if (reset)
            model_q.delete();
        else if (load && model_q.size() <= 1)
            load_word(din);
        else if (model_q.size() > 0)
            void'(model_q.pop_front());
    end

    always @(negedge clock) begin
        if (check_en) begin
            check("x",       64'(x),       64'((model_q.size() > 0) ? model_q[0] : IDLE_BIT));
            check("x_valid", 64'(x_valid), 64'(model_q.size() > 0));
            check("done",    64'(done),    64'(model_q.size() == 1));
            check("ready",   64'(ready),   64'(model_q.size() <= 1));
        end
    end

    // Stream log of valid bits and their done flags, packed first-bit-highest.
    logic [63:0] s_val = '0;
    logic [63:0] d_val = '0;
    int          s_n   = 0;

    always @(negedge clock) begin
        if (x_valid === 1'b1) begin
            s_val = {s_val[62:0], x};
            d_val = {d_val[62:0], done};
            s_n++;
        end
    end

    function automatic logic [63:0] exp_word(input logic [WIDTH-1:0] w);
`ifdef SER_PARITY_EN
        return 64'({w, ^w});
`else
        return 64'(w);
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_log();
        s_val = '0;
        d_val = '0;
        s_n   = 0;
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        din  = w;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        din  = WIDTH'($urandom);
    endtask

    initial begin
        // Power-up reset, then idle outputs must hold while load stays low.
        reset = 1'b1;
        tick(2);
        reset    = 1'b0;
        check_en = 1'b1;
        check("rst_ready",   64'(ready),   64'd1);
        check("rst_x",       64'(x),       64'd0);
        check("rst_x_valid", 64'(x_valid), 64'd0);
        check("rst_done",    64'(done),    64'd0);
        tick(3);
        check("idle_ready",   64'(ready),   64'd1);
        check("idle_x_valid", 64'(x_valid), 64'd0);

        // Single MSB-first word.
        clear_log();
        send(8'b1001_0011);
        check("t2_first_bit", 64'(x), 64'd1);
        tick(NB - 2);
        check("t2_ready_busy", 64'(ready), 64'd0);
        tick(1);
        check("t2_ready_last", 64'(ready), 64'd1);
        check("t2_done_last",  64'(done),  64'd1);
        tick(1);
        check("t2_back_idle", 64'(x_valid), 64'd0);
        tick(2);
        check("t2_len",    64'(s_n), 64'(NB));
        check("t2_stream", s_val,    exp_word(8'b1001_0011));
        check("t2_done",   d_val,    64'd1);

        // Back-to-back words with the second load in the done cycle.
        clear_log();
        send(8'hA5);
        tick(NB - 1);
        send(8'h3C);
        tick(NB + 1);
        check("t3_len",    64'(s_n), 64'(2 * NB));
        check("t3_stream", s_val,    (exp_word(8'hA5) << NB) | exp_word(8'h3C));
        check("t3_done",   d_val,    (64'd1 << NB) | 64'd1);

        // Load while busy is ignored.
        clear_log();
        send(8'h0F);
        tick(2);
        check("t4_ready_mid", 64'(ready), 64'd0);
        send(8'hFF);
        tick(NB - 5);
        check("t4_ready_pre", 64'(ready), 64'd0);
        tick(1);
        check("t4_ready_last", 64'(ready), 64'd1);
        tick(3);
        check("t4_len",    64'(s_n), 64'(NB));
        check("t4_stream", s_val,    exp_word(8'h0F));

        // Reset mid-word, then a clean word, then reset colliding with load.
        send(8'hF0);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_x",       64'(x),       64'(IDLE_BIT));
        check("t5_x_valid", 64'(x_valid), 64'd0);
        check("t5_ready",   64'(ready),   64'd1);
        clear_log();
        send(8'h81);
        tick(NB + 1);
        check("t5_stream", s_val, exp_word(8'h81));
        reset = 1'b1;
        load  = 1'b1;
        din   = 8'hFF;
        tick(1);
        reset = 1'b0;
        load  = 1'b0;
        clear_log();
        tick(3);
        check("t5_load_dropped", 64'(s_n), 64'd0);

        // Literal streams pinning the parity (or plain) framing.
        clear_log();
        send(8'h07);
        tick(NB + 1);
`ifdef SER_PARITY_EN
        check("t6_07", s_val, 64'h00F);
        check("t6_done_pos", d_val, 64'd1);
`else
        check("t6_07", s_val, 64'h07);
`endif
        clear_log();
        send(8'h03);
        tick(NB + 1);
`ifdef SER_PARITY_EN
        check("t6_03", s_val, 64'h006);
`else
        check("t6_03", s_val, 64'h03);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 2) != 0);
            din   = WIDTH'($urandom);
            tick(1);
        end
        reset = 1'b0;
        load  = 1'b0;
        tick(NB + 2);
        check("final_idle", 64'(x_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
